// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: opcodes, sequencer state codes and
// datapath select encodings used by the single- and multi-cycle decoders.
package mips_lite_pkg;

    localparam logic [5:0] OP_RFMT = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IMMEXEC = 4'd10,
        S_IMMWB   = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcode class -> first execute-phase state
    function automatic state_t decode_class(input logic [5:0] op);
        state_t s;
        if (op == OP_RFMT)
            s = S_RTEXEC;
        else if (op == OP_LW || op == OP_SW)
            s = S_MEMADR;
        else if (op == OP_J)
            s = S_JUMP;
        else if (op[5:3] == 3'b000)
            s = S_BRANCH;
        else if (op[5:3] == 3'b001)
            s = S_IMMEXEC;
        else
            s = S_TRAP;
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; flags the last cycle an access may still
// complete before the sequencer gives up and traps.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);

    logic [TOW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + TOW'(1);
    end

    assign o_timeout = (r_cnt == TOW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-lite sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// memory-ready handshake, wait timeout and sticky trap on illegal opcodes.
module multicycle_control
    import mips_lite_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       regdest,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       isimmpart,
    output logic       trap,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic       r_trap;
    logic       w_wait;
    logic       w_timeout;
    logic       w_isimm;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                    (r_state == S_MEMWR);
    assign w_isimm = r_op[3] && (r_op != 6'b111111);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TOW        (TOW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_wait || mem_ready),
        .i_inc    (w_wait && !mem_ready),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= op;
            if (w_next == S_TRAP)
                r_trap <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        regdest     = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUSRCB_B;
        aluop       = ALUOP_ADD;
        pcsource    = PCSRC_ALU;
        isimmpart   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = ALUSRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready)
                    w_next = S_DECODE;
                else if (w_timeout)
                    w_next = S_TRAP;
            end
            S_DECODE: begin
                alusrcb = ALUSRCB_IMMSH;
                w_next  = decode_class(op);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                w_next  = r_op[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
                else if (w_timeout)
                    w_next = S_TRAP;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    w_next = S_FETCH;
                else if (w_timeout)
                    w_next = S_TRAP;
            end
            S_RTEXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                w_next  = S_RTWB;
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
                w_next   = S_FETCH;
            end
            S_IMMEXEC: begin
                alusrca   = 1'b1;
                alusrcb   = ALUSRCB_IMM;
                aluop     = ALUOP_IMM;
                isimmpart = w_isimm;
                w_next    = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite  = 1'b1;
                isimmpart = w_isimm;
                w_next    = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    assign trap  = r_trap;
    assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and full
// control-vector checks against hand-computed values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regwrite, regdest, alusrca, isimmpart, trap;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;
    logic [17:0] outs;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .pcwritecond(pcwritecond),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .regdest    (regdest),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsource   (pcsource),
        .isimmpart  (isimmpart),
        .trap       (trap),
        .state      (state)
    );

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regwrite,
    //  regdest,alusrca,alusrcb,aluop,pcsource,isimmpart,trap}
    assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                   memtoreg, regwrite, regdest, alusrca, alusrcb, aluop,
                   pcsource, isimmpart, trap};

    localparam logic [17:0] E_FETCH_RDY  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_FETCH_WAIT = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_DECODE     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMADR     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMRD      = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWB      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWR      = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_RTEXEC     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_RTWB       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] E_BRANCH     = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [17:0] E_JUMP       = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [17:0] E_IMMEXEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] E_IMMWB      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] E_TRAP       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [17:0] obs,
                       input logic [17:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the current cycle, then advance to 1 time unit past the next edge
    task automatic step(input string tag, input logic [3:0] es,
                        input logic [17:0] eo);
        #1;
        chk({tag, ".state"}, 18'(state), 18'(es));
        chk({tag, ".out"}, outs, eo);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, ".state"}, 18'(state), 18'd0);
        chk({tag, ".trap"}, 18'(trap), 18'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset", 4'd0, E_FETCH_WAIT);
        rst_n = 1'b1;

        op = 6'b100011;
        mem_ready = 1'b1;
        step("lw.c1", 4'd0, E_FETCH_RDY);
        step("lw.c2", 4'd1, E_DECODE);
        step("lw.c3", 4'd2, E_MEMADR);
        step("lw.c4", 4'd3, E_MEMRD);
        step("lw.c5", 4'd4, E_MEMWB);

        op = 6'b000000;
        mem_ready = 1'b0;
        step("rt.c1", 4'd0, E_FETCH_WAIT);
        step("rt.c2", 4'd0, E_FETCH_WAIT);
        step("rt.c3", 4'd0, E_FETCH_WAIT);
        mem_ready = 1'b1;
        step("rt.c4", 4'd0, E_FETCH_RDY);
        mem_ready = 1'b0;
        step("rt.c5", 4'd1, E_DECODE);
        step("rt.c6", 4'd6, E_RTEXEC);
        step("rt.c7", 4'd7, E_RTWB);

        op = 6'b101011;
        mem_ready = 1'b1;
        step("sw.c1", 4'd0, E_FETCH_RDY);
        op = 6'b101011;
        step("sw.c2", 4'd1, E_DECODE);
        op = 6'b000000;
        step("sw.c3", 4'd2, E_MEMADR);
        step("sw.c4", 4'd5, E_MEMWR);

        op = 6'b000100;
        step("beq.c1", 4'd0, E_FETCH_RDY);
        step("beq.c2", 4'd1, E_DECODE);
        step("beq.c3", 4'd8, E_BRANCH);

        op = 6'b000010;
        step("j.c1", 4'd0, E_FETCH_RDY);
        step("j.c2", 4'd1, E_DECODE);
        step("j.c3", 4'd9, E_JUMP);

        op = 6'b001000;
        step("addi.c1", 4'd0, E_FETCH_RDY);
        step("addi.c2", 4'd1, E_DECODE);
        step("addi.c3", 4'd10, E_IMMEXEC);
        step("addi.c4", 4'd11, E_IMMWB);

        op = 6'b110000;
        step("ill.c1", 4'd0, E_FETCH_RDY);
        step("ill.c2", 4'd1, E_DECODE);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step("ill.hold", 4'd12, E_TRAP);
        end
        pulse_reset("ill.rst");
        mem_ready = 1'b0;
        step("ill.after", 4'd0, E_FETCH_WAIT);

        op = 6'b100011;
        mem_ready = 1'b1;
        step("to.c1", 4'd0, E_FETCH_RDY);
        step("to.c2", 4'd1, E_DECODE);
        step("to.c3", 4'd2, E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            step("to.wait", 4'd3, E_MEMRD);
        step("to.trap", 4'd12, E_TRAP);
        pulse_reset("to.rst");

        mem_ready = 1'b1;
        step("late.c1", 4'd0, E_FETCH_RDY);
        step("late.c2", 4'd1, E_DECODE);
        step("late.c3", 4'd2, E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++)
            step("late.wait", 4'd3, E_MEMRD);
        mem_ready = 1'b1;
        step("late.last", 4'd3, E_MEMRD);
        step("late.wb", 4'd4, E_MEMWB);

        op = 6'b101011;
        step("abort.c1", 4'd0, E_FETCH_RDY);
        step("abort.c2", 4'd1, E_DECODE);
        step("abort.c3", 4'd2, E_MEMADR);
        mem_ready = 1'b0;
        #1;
        chk("abort.memwr", outs, E_MEMWR);
        rst_n = 1'b0;
        #1;
        chk("abort.state", 18'(state), 18'd0);
        chk("abort.out", outs, E_FETCH_WAIT);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("abort.r1", 4'd0, E_FETCH_WAIT);
        step("abort.r2", 4'd0, E_FETCH_WAIT);
        mem_ready = 1'b1;
        step("abort.r3", 4'd0, E_FETCH_RDY);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
